// File: rtl/ysyx_22040759_alu_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between two
// requesters. It grants at most one operation per cycle and registers each
// requester's result in its own output slot. The sel code is passed through
// to the ALU without being decoded.
module ysyx_22040759_alu_arbiter #(
    parameter int DW    = 64,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    // requester 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [DW-1:0]    req0_a,
    input  logic [DW-1:0]    req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [DW-1:0]    resp0_result,
    // requester 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [DW-1:0]    req1_a,
    input  logic [DW-1:0]    req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [DW-1:0]    resp1_result,
    // shared ALU
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [DW-1:0]    alu_result
);

    // Round-robin pointer: the requester that wins when both are eligible.
    logic ptr;
    logic elig0, elig1;
    logic grant0, grant1;

    // A requester is eligible when its slot is empty or is being drained this
    // cycle. Grants are forced off while reset is held.
    always_comb begin
        elig0  = req0_valid && (!resp0_valid || resp0_ready);
        elig1  = req1_valid && (!resp1_valid || resp1_ready);
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (elig0 && elig1) begin
                grant0 = !ptr;
                grant1 = ptr;
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Steer the granted requester's operands to the ALU. Drive zeros when idle.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = '0;
        if (grant0) begin
            alu_a   = req0_a;
            alu_b   = req0_b;
            alu_sel = req0_sel;
        end else if (grant1) begin
            alu_a   = req1_a;
            alu_b   = req1_b;
            alu_sel = req1_sel;
        end
    end

    // After a grant, priority passes to the requester that was not served.
    // The pointer holds when there is no grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (grant0) begin
            ptr <= 1'b1;
        end else if (grant1) begin
            ptr <= 1'b0;
        end
    end

    // Requester 0 result slot. A grant refills it and wins over a drain that
    // happens in the same cycle. A drain alone only clears valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp0_valid  <= 1'b0;
            resp0_result <= '0;
        end else if (grant0) begin
            resp0_valid  <= 1'b1;
            resp0_result <= alu_result;
        end else if (resp0_ready) begin
            resp0_valid  <= 1'b0;
        end
    end

    // Requester 1 result slot. It follows the same rules as slot 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp1_valid  <= 1'b0;
            resp1_result <= '0;
        end else if (grant1) begin
            resp1_valid  <= 1'b1;
            resp1_result <= alu_result;
        end else if (resp1_ready) begin
            resp1_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_22040759_alu_arbiter.sv
// Directed bench for ysyx_22040759_alu_arbiter. The bench contains a small
// ALU model (add / or) that plays the part of the parent's ALU instance.
module tb_ysyx_22040759_alu_arbiter;

    localparam int DW    = 64;
    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] ALU_ADD = 3'b001;
    localparam logic [SEL_W-1:0] ALU_OR  = 3'b010;
    localparam logic [DW-1:0]    ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, resp0_valid, resp0_ready;
    logic [DW-1:0]    req0_a, req0_b, resp0_result;
    logic [SEL_W-1:0] req0_sel;
    logic             req1_valid, req1_ready, resp1_valid, resp1_ready;
    logic [DW-1:0]    req1_a, req1_b, resp1_result;
    logic [SEL_W-1:0] req1_sel;
    logic [DW-1:0]    alu_a, alu_b, alu_result;
    logic [SEL_W-1:0] alu_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Reference ALU
    assign alu_result = (alu_sel == ALU_ADD) ? alu_a + alu_b :
                        (alu_sel == ALU_OR)  ? (alu_a | alu_b) : '0;

    ysyx_22040759_alu_arbiter #(.DW(DW), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result)
    );

    typedef struct {
        logic             v0;
        logic [DW-1:0]    a0;
        logic [DW-1:0]    b0;
        logic [SEL_W-1:0] s0;
        logic             v1;
        logic [DW-1:0]    a1;
        logic [DW-1:0]    b1;
        logic [SEL_W-1:0] s1;
        logic             rr0;
        logic             rr1;
        logic             e_rdy0;
        logic             e_rdy1;
        logic [DW-1:0]    e_alu_a;
        logic             e_rv0;
        logic [DW-1:0]    e_res0;
        logic             e_rv1;
        logic [DW-1:0]    e_res1;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req0_valid  = v.v0;  req0_a = v.a0; req0_b = v.b0; req0_sel = v.s0;
        req1_valid  = v.v1;  req1_a = v.a1; req1_b = v.b1; req1_sel = v.s1;
        resp0_ready = v.rr0; resp1_ready = v.rr1;
    endtask

    initial begin
        // v0 a0 b0 s0 | v1 a1 b1 s1 | rr0 rr1 | rdy0 rdy1 alu_a | rv0 res0 | rv1 res1
        // 1: single r0 add, 5+7
        vecs[0]  = '{1'b1, 64'd5,  64'd7,  ALU_ADD, 1'b0, 64'd0,   64'd0,  ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 64'd5,   1'b1, 64'd12, 1'b0, 64'd0};
        // 2: dual demand alternates; ptr=1, so r1 goes first
        vecs[1]  = '{1'b1, 64'd1,  64'd2,  ALU_ADD, 1'b1, 64'd10,  64'd20, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 64'd10,  1'b0, 64'd12, 1'b1, 64'd30};
        vecs[2]  = '{1'b1, 64'd1,  64'd2,  ALU_ADD, 1'b1, 64'd10,  64'd20, ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 64'd1,   1'b1, 64'd3,  1'b0, 64'd30};
        vecs[3]  = '{1'b1, 64'd1,  64'd2,  ALU_ADD, 1'b1, 64'd100, 64'd5,  ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 64'd100, 1'b0, 64'd3,  1'b1, 64'd105};
        vecs[4]  = '{1'b1, 64'd4,  64'd4,  ALU_ADD, 1'b1, 64'd100, 64'd5,  ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 64'd4,   1'b1, 64'd8,  1'b0, 64'd105};
        // 3: r0 back-pressured, so r1 wins back-to-back and res0 holds
        vecs[5]  = '{1'b1, 64'd6,  64'd3,  ALU_ADD, 1'b1, 64'd1,   64'd1,  ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 64'd1,   1'b1, 64'd8,  1'b1, 64'd2};
        vecs[6]  = '{1'b1, 64'd6,  64'd3,  ALU_ADD, 1'b1, 64'd2,   64'd2,  ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 64'd2,   1'b1, 64'd8,  1'b1, 64'd4};
        //    release resp0_ready: r0 is granted in that same cycle
        vecs[7]  = '{1'b1, 64'd6,  64'd3,  ALU_ADD, 1'b1, 64'd2,   64'd2,  ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 64'd6,   1'b1, 64'd9,  1'b0, 64'd4};
        // 4: full r0 slot drained and refilled with no bubble
        vecs[8]  = '{1'b1, 64'd20, 64'd22, ALU_ADD, 1'b0, 64'd0,   64'd0,  ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 64'd20,  1'b1, 64'd42, 1'b0, 64'd4};
        // 5: OR on r1, then add wrap-around on r0 while r1 holds its result
        vecs[9]  = '{1'b0, 64'd0,  64'd0,  ALU_ADD, 1'b1, 64'hF0,  64'h0F, ALU_OR,  1'b1, 1'b1, 1'b0, 1'b1, 64'hF0,  1'b0, 64'd42, 1'b1, 64'hFF};
        vecs[10] = '{1'b1, ONES,   ONES,   ALU_ADD, 1'b0, 64'd0,   64'd0,  ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0, ONES,    1'b1, ONES - 64'd1, 1'b1, 64'hFF};
        // idle cycle: no grant, ALU driven to zero, both slots hold, ptr holds (=1)
        vecs[11] = '{1'b0, 64'd3,  64'd3,  ALU_ADD, 1'b0, 64'd3,   64'd3,  ALU_OR,  1'b0, 1'b0, 1'b0, 1'b0, 64'd0,   1'b1, ONES - 64'd1, 1'b1, 64'hFF};
        // the pointer held through the idle cycle, so r1 wins here
        vecs[12] = '{1'b1, 64'd1,  64'd1,  ALU_ADD, 1'b1, 64'd7,   64'd8,  ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 64'd7,   1'b0, ONES - 64'd1, 1'b1, 64'd15};

        // Reset with a request pending: ready must stay low and the slots empty
        rst = 1'b1;
        drive(vecs[0]);
        #1;
        chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid0", {63'd0, resp0_valid}, 64'd0);
        chk("rst_valid1", {63'd0, resp1_valid}, 64'd0);
        chk("rst_res0", resp0_result, 64'd0);
        chk("rst_res1", resp1_result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_rdy0", i), {63'd0, req0_ready}, {63'd0, vecs[i].e_rdy0});
            chk($sformatf("v%0d_rdy1", i), {63'd0, req1_ready}, {63'd0, vecs[i].e_rdy1});
            chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].e_alu_a);
            if (!vecs[i].e_rdy0 && !vecs[i].e_rdy1)
                chk($sformatf("v%0d_alu_sel", i), {61'd0, alu_sel}, 64'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rv0", i), {63'd0, resp0_valid}, {63'd0, vecs[i].e_rv0});
            chk($sformatf("v%0d_res0", i), resp0_result, vecs[i].e_res0);
            chk($sformatf("v%0d_rv1", i), {63'd0, resp1_valid}, {63'd0, vecs[i].e_rv1});
            chk($sformatf("v%0d_res1", i), resp1_result, vecs[i].e_res1);
        end

        // Fill both slots: r0 is granted while r1 holds its result (15)
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 64'd9; req0_b = 64'd9; req0_sel = ALU_ADD;
        req1_valid = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("fill_rv0", {63'd0, resp0_valid}, 64'd1);
        chk("fill_res0", resp0_result, 64'd18);
        chk("fill_rv1", {63'd0, resp1_valid}, 64'd1);

        // Asynchronous reset mid-cycle: slots clear before the next edge
        @(negedge clk);
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 64'd2; req1_b = 64'd3; req1_sel = ALU_ADD;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rv0", {63'd0, resp0_valid}, 64'd0);
        chk("arst_rv1", {63'd0, resp1_valid}, 64'd0);
        chk("arst_res0", resp0_result, 64'd0);
        chk("arst_res1", resp1_result, 64'd0);
        chk("arst_rdy0", {63'd0, req0_ready}, 64'd0);
        chk("arst_rdy1", {63'd0, req1_ready}, 64'd0);

        // After release with both requesting, r0 is granted first and then r1
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rdy0", {63'd0, req0_ready}, 64'd1);
        chk("post_rdy1", {63'd0, req1_ready}, 64'd0);
        @(posedge clk);
        #1;
        chk("post_rv0", {63'd0, resp0_valid}, 64'd1);
        chk("post_res0", resp0_result, 64'd18);
        chk("post_rdy1b", {63'd0, req1_ready}, 64'd1);
        @(posedge clk);
        #1;
        chk("post_rv1", {63'd0, resp1_valid}, 64'd1);
        chk("post_res1", resp1_result, 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
